// File: rtl/neuron_mac_seq_if.sv
// ==========================================================================
// Module : neuron_mac_seq_if
// Stream, weight-memory and result signals of one neuron MAC sequencer.
// Rev    : 1.0
// ==========================================================================
`default_nettype none

interface neuron_mac_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  start;
  logic                  x_valid;
  logic                  x_ready;
  logic [DATA_WIDTH-1:0] x_in;
  logic                  w_ren;
  logic [ADDR_WIDTH-1:0] w_radd;
  logic [DATA_WIDTH-1:0] w_in;
  logic [DATA_WIDTH-1:0] bias_in;
  logic [DATA_WIDTH-1:0] y_out;
  logic                  y_valid;
  logic                  busy;

  modport slave (
    input  start, x_valid, x_in, w_in, bias_in,
    output x_ready, w_ren, w_radd, y_out, y_valid, busy
  );

  modport master (
    output start, x_valid, x_in, w_in, bias_in,
    input  x_ready, w_ren, w_radd, y_out, y_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/neuron_mac_seq.sv
// ==========================================================================
// Module : neuron_mac_seq
// Neuron sequencer/MAC: streams activations, reads weights, adds bias,
// saturates. Define NEURON_RELU_EN to clamp negative results to zero.
// Rev    : 1.0
// ==========================================================================
`default_nettype none

module neuron_mac_seq #(
  parameter int NUM_WEIGHT = 10,
  parameter int ADDR_WIDTH = $clog2(NUM_WEIGHT),
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 12
) (
  input  logic               clk,
  input  logic               rst,
  neuron_mac_seq_if.slave    bus
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = 2 * DATA_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WEIGHT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_BIAS  = 2'd3
  } state_t;

  state_t state, state_next;

  logic                         in_load;
  logic                         accept;
  logic [ADDR_WIDTH-1:0]        count;
  logic signed [DATA_WIDTH-1:0] x_d;
  logic                         prod_v;
  logic signed [ACC_W-1:0]      acc;
  logic signed [PROD_W-1:0]     prod;
  logic signed [PROD_W-1:0]     prod_sh;
  logic signed [ACC_W-1:0]      prod_ext;
  logic signed [ACC_W-1:0]      sum;
  logic signed [DATA_WIDTH-1:0] sat;
  logic signed [DATA_WIDTH-1:0] y_next;
  logic [DATA_WIDTH-1:0]        y_q;
  logic                         y_v;

  assign in_load = (state == S_LOAD);
  assign accept  = bus.x_valid & in_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.start) state_next = S_LOAD;
      S_LOAD:  if (accept && (count == LAST_IDX)) state_next = S_DRAIN;
      S_DRAIN: state_next = S_BIAS;
      S_BIAS:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Weight data lands one cycle after the read, alongside the registered x_d.
  always_comb begin
    prod     = PROD_W'(x_d) * PROD_W'($signed(bus.w_in));
    prod_sh  = prod >>> FRAC_BITS;
    prod_ext = ACC_W'(prod_sh);
    sum      = acc + ACC_W'($signed(bus.bias_in));
  end

  always_comb begin
    if (sum > SAT_MAX) begin
      sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (sum < SAT_MIN) begin
      sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      sat = sum[DATA_WIDTH-1:0];
    end
`ifdef NEURON_RELU_EN
    y_next = sat[DATA_WIDTH-1] ? '0 : sat;
`else
    y_next = sat;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      acc    <= '0;
      x_d    <= '0;
      prod_v <= 1'b0;
      y_q    <= '0;
      y_v    <= 1'b0;
    end else begin
      prod_v <= accept;
      y_v    <= (state == S_BIAS);
      if (accept) begin
        x_d   <= $signed(bus.x_in);
        count <= count + 1'b1;
      end
      if ((state == S_IDLE) && bus.start) begin
        count <= '0;
        acc   <= '0;
      end else if (prod_v) begin
        acc <= acc + prod_ext;
      end
      if (state == S_BIAS) begin
        y_q <= y_next;
      end
    end
  end

  assign bus.x_ready = in_load;
  assign bus.w_ren   = accept;
  assign bus.w_radd  = in_load ? count : '0;
  assign bus.y_out   = y_q;
  assign bus.y_valid = y_v;
  assign bus.busy    = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_neuron_mac_seq.sv
// Scoreboard bench for neuron_mac_seq: directed evaluations push expected
// results; a negedge monitor pops and compares on every y_valid.
`default_nettype none

module tb_neuron_mac_seq;
  localparam int NW = 10;
  localparam int AW = 4;
  localparam int DW = 16;

  typedef struct {
    logic [DW-1:0] y;
    int            due;
  } exp_t;

  logic          clk;
  logic          rst;
  int            cyc      = 0;
  int            checks   = 0;
  int            passes   = 0;
  int            exp_addr = 0;
  exp_t          exp_q[$];
  logic [DW-1:0] wmem [0:15];

  neuron_mac_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  neuron_mac_seq #(
    .NUM_WEIGHT(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAC_BITS(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Weight memory with one-cycle registered read.
  always @(posedge clk) begin
    if (bus.w_ren) bus.w_in <= wmem[bus.w_radd];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef NEURON_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (bus.y_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_y_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("y_out", bus.y_out, e.y);
          chk("y_valid_cycle", cyc, e.due);
        end
      end
      if (bus.w_ren) begin
        chk("w_radd", bus.w_radd, exp_addr);
        exp_addr++;
      end
      chk("w_ren_handshake", bus.w_ren, bus.x_valid & bus.x_ready);
      if (!bus.busy) chk("idle_outputs", {bus.w_ren, bus.x_ready, bus.w_radd}, 32'd0);
    end
  end

  task automatic fill(input logic [DW-1:0] w);
    for (int i = 0; i < 16; i++) wmem[i] = w;
  endtask

  task automatic beat(input logic [DW-1:0] x, output int lc);
    int n;
    n = 0;
    bus.x_valid = 1'b1;
    bus.x_in    = x;
    while (!bus.x_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) chk("x_ready_timeout", 32'd0, 32'd1);
    lc = cyc;
    @(posedge clk); #1;
    bus.x_valid = 1'b0;
  endtask

  task automatic run_eval(input logic [DW-1:0] x, input logic [DW-1:0] bias,
                          input logic [DW-1:0] expv, input bit gaps, input bit extra);
    int   lc;
    exp_t e;
    bus.bias_in = bias;
    exp_addr    = 0;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (extra && i == 3) bus.start = 1'b1;
      beat(x, lc);
      bus.start = 1'b0;
      if (gaps && i < NW - 1) begin
        @(posedge clk); #1;
      end
    end
    e.y   = expv;
    e.due = lc + 3;
    exp_q.push_back(e);
    if (extra) begin
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int lc;
    int n;
    bus.start   = 1'b0;
    bus.x_valid = 1'b0;
    bus.x_in    = '0;
    bus.bias_in = '0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_y_out",   bus.y_out,   32'h0);
    chk("rst_y_valid", bus.y_valid, 32'h0);
    chk("rst_busy",    bus.busy,    32'h0);
    chk("rst_x_ready", bus.x_ready, 32'h0);

    fill(16'h1000);
    run_eval(16'h0800, 16'h0000, relu(16'h5000), 1'b0, 1'b0);

    fill(16'h7FFF);
    run_eval(16'h7FFF, 16'h7FFF, relu(16'h7FFF), 1'b0, 1'b0);

    fill(16'hF000);
    run_eval(16'h1000, 16'h0000, relu(16'h8000), 1'b0, 1'b0);

    // 10 x 1.0 + 0.5 exceeds the range and clamps.
    fill(16'h1000);
    run_eval(16'h1000, 16'h0800, relu(16'h7FFF), 1'b1, 1'b0);
    run_eval(16'h0400, 16'h0800, relu(16'h3000), 1'b1, 1'b0);

    // Abort after five beats.
    bus.bias_in = '0;
    exp_addr    = 0;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) beat(16'h1000, lc);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy",    bus.busy,    32'h0);
    chk("abort_y_valid", bus.y_valid, 32'h0);
    chk("abort_x_ready", bus.x_ready, 32'h0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) wmem[i] = 16'((i + 1) * 16'h0100);
    run_eval(16'h1000, 16'hFF00, relu(16'h3600), 1'b0, 1'b0);

    fill(16'h1000);
    run_eval(16'h0800, 16'h0000, relu(16'h5000), 1'b0, 1'b1);

    // -1 LSB products truncate toward minus infinity.
    fill(16'h0001);
    run_eval(16'hFFFF, 16'h0000, relu(16'hFFF6), 1'b0, 1'b0);

    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) chk("result_timeout", exp_q.size(), 32'd0);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
